wb_initiator: RTL and testbench

- Wishbone classic-cycle bus master: the initiator end of the wbs_* slave interface used by the register/memory blocks.
- Accepts single or incrementing-burst read/write commands on a valid/ready command port and drives the Wishbone cycle.
- Returns one response per beat on a valid/ready response port.
- Used by test/DMA logic inside the user area to program registers and fill the LED buffer memory without the management core.

---
 rtl/wb_initiator_pkg.sv | 13 +
 rtl/wb_initiator.sv | 130 +++++++++++++
 tb/tb_wb_initiator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg: shared FSM state type and constants for the Wishbone initiator
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    localparam logic [31:0] ADR_INC = 32'd4;
    localparam logic [31:0] ERR_DAT = 32'h0;

endpackage

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic-cycle master with valid/ready command and response ports
// Optional macro WB_INITIATOR_TIMEOUT_EN enables the per-beat ack timeout and rsp_err.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TSIZE   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    if (TIMEOUT >= (1 << TSIZE)) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT must be below 2**TSIZE");
    end

    state_t     state;
    logic [3:0] beats_left;
`ifdef WB_INITIATOR_TIMEOUT_EN
    logic [TSIZE-1:0] cnt;
`endif

    // Command acceptance, beat sequencing and response hand-off in one registered FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beats_left <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_err    <= 1'b0;
            rsp_last   <= 1'b0;
            busy       <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o   <= cmd_we;
                        wbm_adr_o  <= cmd_adr;
                        wbm_dat_o  <= cmd_dat;
                        wbm_sel_o  <= cmd_sel;
                        beats_left <= cmd_len;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        busy       <= 1'b1;
                        cmd_ready  <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        cnt        <= '0;
`endif
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the expiry cycle still completes the beat normally
                    if (wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? ERR_DAT : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_last  <= (beats_left == 4'd0);
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
`ifdef WB_INITIATOR_TIMEOUT_EN
                    else if (cnt == TSIZE'(TIMEOUT)) begin
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= ERR_DAT;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last || rsp_err) begin
                            wbm_cyc_o <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wbm_adr_o  <= wbm_adr_o + ADR_INC;
                            beats_left <= beats_left - 4'd1;
                            wbm_stb_o  <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
                            cnt        <= '0;
`endif
                            state      <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed table-driven bench for the Wishbone initiator
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic [3:0]  cmd_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_adr_o;
    logic        wbm_we_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    logic ack_en = 1'b1;
    logic stray = 1'b0;
    logic ack_q;

    int checks = 0;
    int failures = 0;

    wb_initiator #(.TSIZE(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
        .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    // Registered-ack slave: acks one cycle after seeing a strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= ack_en & wbm_cyc_o & wbm_stb_o & ~ack_q;
    end
    assign wbm_ack_i = ack_q | stray;
    assign wbm_dat_i = 32'hA0 + {30'd0, wbm_adr_o[3:2]};

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [3:0]  len;
        int          bp;
        logic [31:0] exp_last_adr;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return 32'hA0 + {30'd0, a[3:2]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        logic [31:0] a;
        logic [31:0] seen;
        int n;
        seen = '0;
        cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel; cmd_len = v.len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_cmd_ready", cmd_ready, 0);
        for (int b = 0; b <= int'(v.len); b++) begin
            a = v.adr + 32'(4 * b);
            n = 0;
            while (!wbm_stb_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("stb_delay b%0d", b), n, 0);
            check($sformatf("adr b%0d", b), wbm_adr_o, a);
            check($sformatf("we b%0d", b), wbm_we_o, v.we);
            check($sformatf("wdat b%0d", b), wbm_dat_o, v.dat);
            check($sformatf("sel b%0d", b), wbm_sel_o, v.sel);
            check($sformatf("cyc b%0d", b), wbm_cyc_o, 1);
            seen = wbm_adr_o;
            @(negedge clk);
            check($sformatf("rsp_early b%0d", b), rsp_valid, 0);
            @(negedge clk);
            check($sformatf("rsp_valid b%0d", b), rsp_valid, 1);
            check($sformatf("stb_low b%0d", b), wbm_stb_o, 0);
            check($sformatf("cyc_held b%0d", b), wbm_cyc_o, 1);
            check($sformatf("rsp_dat b%0d", b), rsp_dat, v.we ? 32'h0 : rd_model(a));
            check($sformatf("rsp_err b%0d", b), rsp_err, 0);
            check($sformatf("rsp_last b%0d", b), rsp_last, b == int'(v.len));
            if (b == v.bp) begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_stb", wbm_stb_o, 0);
                    check("bp_adr", wbm_adr_o, a);
                    check("bp_rsp_valid", rsp_valid, 1);
                    check("bp_rsp_dat", rsp_dat, rd_model(a));
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        check("end_busy", busy, 0);
        check("end_cyc", wbm_cyc_o, 0);
        check("end_rsp_valid", rsp_valid, 0);
        check("end_cmd_ready", cmd_ready, 1);
        check("last_adr", seen, v.exp_last_adr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 32'h3003_0004, 32'h1234_5678, 4'hF, 4'd0, -1, 32'h3003_0004};
        vecs[1] = '{1'b0, 32'h3003_1000, 32'h0,         4'hF, 4'd3, -1, 32'h3003_100C};
        vecs[2] = '{1'b0, 32'h3003_1000, 32'h0,         4'hF, 4'd3,  0, 32'h3003_100C};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 4'd1, -1, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'h3, 4'd2, -1, 32'h3000_0018};

        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_last", rsp_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_rsp_valid", rsp_valid, 0);
        check("stray_busy", busy, 0);
        check("stray_cmd_ready", cmd_ready, 1);

        cmd_we = 1'b0; cmd_adr = 32'h3003_1000; cmd_dat = '0; cmd_sel = 4'hF; cmd_len = 4'd3;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(wbm_stb_o && wbm_adr_o == 32'h3003_1004) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", (n < 50) ? 1 : 0, 1);
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("mid_rst_cyc", wbm_cyc_o, 0);
        check("mid_rst_stb", wbm_stb_o, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(vecs[1]);

`ifdef WB_INITIATOR_TIMEOUT_EN
        ack_en = 1'b0;
        cmd_we = 1'b0; cmd_adr = 32'h3003_2000; cmd_sel = 4'hF; cmd_len = 4'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (wbm_stb_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, 17);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_dat", rsp_dat, 0);
        check("to_rsp_last", rsp_last, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("to_busy", busy, 0);
        check("to_no_more_stb", wbm_stb_o, 0);
        check("to_cmd_ready", cmd_ready, 1);

        cmd_len = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("exp_stb_still", wbm_stb_o, 1);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("exp_rsp_valid", rsp_valid, 1);
        check("exp_rsp_err", rsp_err, 0);
        check("exp_rsp_dat", rsp_dat, 32'hA0);
        check("exp_rsp_last", rsp_last, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("exp_busy", busy, 0);
        ack_en = 1'b1;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
